// File: rtl/register_bank_reader_if.sv
// Bus bundle for register_bank_reader: write port, dual read port and dump stream.
interface register_bank_reader_if #(
  parameter int WIDTH     = 32,
  parameter int ADDR_BITS = 5
);
  logic                 writeEnable;
  logic [ADDR_BITS-1:0] writeAddr;
  logic [WIDTH-1:0]     writeData;
  logic                 readReq;
  logic [ADDR_BITS-1:0] readAddr1;
  logic [ADDR_BITS-1:0] readAddr2;
  logic [WIDTH-1:0]     readData1;
  logic [WIDTH-1:0]     readData2;
  logic                 readValid;
  logic                 dumpStart;
  logic                 busy;
  logic                 dumpValid;
  logic [ADDR_BITS-1:0] dumpAddr;
  logic [WIDTH-1:0]     dumpData;
  logic                 dumpDone;

  modport master (
    output writeEnable, writeAddr, writeData, readReq, readAddr1, readAddr2, dumpStart,
    input  readData1, readData2, readValid, busy, dumpValid, dumpAddr, dumpData, dumpDone
  );

  modport slave (
    input  writeEnable, writeAddr, writeData, readReq, readAddr1, readAddr2, dumpStart,
    output readData1, readData2, readValid, busy, dumpValid, dumpAddr, dumpData, dumpDone
  );
endinterface

// File: rtl/register_bank_reader.sv
// Register bank with two registered read ports, write->read forwarding and a
// sequential dump engine streaming every entry out one per cycle.
module register_bank_reader #(
  parameter int WIDTH     = 32,
  parameter int ADDR_BITS = 5,
  parameter int ZERO_REG  = 1
) (
  input  logic                 clk,
  input  logic                 reset,
  register_bank_reader_if.slave bus
);

  localparam int unsigned DEPTH = 1 << ADDR_BITS;
  localparam logic [0:0]  S_IDLE = 1'b0;
  localparam logic [0:0]  S_DUMP = 1'b1;

  logic [WIDTH-1:0]     r_mem [DEPTH];
  logic [0:0]           r_state;
  logic [ADDR_BITS-1:0] r_idx;
  logic [WIDTH-1:0]     r_rd1;
  logic [WIDTH-1:0]     r_rd2;
  logic                 r_rd_valid;
  logic [ADDR_BITS-1:0] r_dump_addr;
  logic [WIDTH-1:0]     r_dump_data;
  logic                 r_dump_valid;
  logic                 r_dump_done;

  logic                 w_wr_ok;
  logic [WIDTH-1:0]     w_rd1;
  logic [WIDTH-1:0]     w_rd2;
  logic [WIDTH-1:0]     w_dump;

  // A dropped write to the zero entry must not be forwarded either.
  assign w_wr_ok = bus.writeEnable && !((ZERO_REG != 0) && (bus.writeAddr == '0));

  always_comb begin
    w_rd1  = r_mem[bus.readAddr1];
    w_rd2  = r_mem[bus.readAddr2];
    w_dump = r_mem[r_idx];
    if (w_wr_ok && (bus.writeAddr == bus.readAddr1)) w_rd1  = bus.writeData;
    if (w_wr_ok && (bus.writeAddr == bus.readAddr2)) w_rd2  = bus.writeData;
    if (w_wr_ok && (bus.writeAddr == r_idx))         w_dump = bus.writeData;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int unsigned i = 0; i < DEPTH; i++) r_mem[i[ADDR_BITS-1:0]] <= '0;
    end else if (w_wr_ok) begin
      r_mem[bus.writeAddr] <= bus.writeData;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_rd1      <= '0;
      r_rd2      <= '0;
      r_rd_valid <= 1'b0;
    end else begin
      r_rd_valid <= bus.readReq;
      if (bus.readReq) begin
        r_rd1 <= w_rd1;
        r_rd2 <= w_rd2;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state      <= S_IDLE;
      r_idx        <= '0;
      r_dump_addr  <= '0;
      r_dump_data  <= '0;
      r_dump_valid <= 1'b0;
      r_dump_done  <= 1'b0;
    end else begin
      r_dump_valid <= 1'b0;
      r_dump_done  <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (bus.dumpStart) begin
            r_state <= S_DUMP;
            r_idx   <= '0;
          end
        end
        S_DUMP: begin
          r_dump_addr  <= r_idx;
          r_dump_data  <= w_dump;
          r_dump_valid <= 1'b1;
          r_idx        <= r_idx + ADDR_BITS'(1);
          if (r_idx == '1) begin
            r_dump_done <= 1'b1;
            r_state     <= S_IDLE;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign bus.readData1 = r_rd1;
  assign bus.readData2 = r_rd2;
  assign bus.readValid = r_rd_valid;
  assign bus.busy      = (r_state == S_DUMP);
  assign bus.dumpValid = r_dump_valid;
  assign bus.dumpAddr  = r_dump_addr;
  assign bus.dumpData  = r_dump_data;
  assign bus.dumpDone  = r_dump_done;

endmodule

// File: tb/tb_register_bank_reader.sv
// Directed bench for register_bank_reader: one instance with ZERO_REG=1, one with ZERO_REG=0.
module tb_register_bank_reader;

  logic clk = 1'b0;
  logic reset = 1'b0;
  int   n_checks = 0;
  int   n_errors = 0;
  logic [31:0] exp_dump [32];

  register_bank_reader_if #(.WIDTH(32), .ADDR_BITS(5)) if0 ();
  register_bank_reader_if #(.WIDTH(32), .ADDR_BITS(5)) if1 ();

  register_bank_reader #(.WIDTH(32), .ADDR_BITS(5), .ZERO_REG(1)) u_dut (
    .clk(clk), .reset(reset), .bus(if0.slave)
  );
  register_bank_reader #(.WIDTH(32), .ADDR_BITS(5), .ZERO_REG(0)) u_dut0 (
    .clk(clk), .reset(reset), .bus(if1.slave)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    if0.writeEnable = 0; if0.writeAddr = 0; if0.writeData = 0; if0.readReq = 0;
    if0.readAddr1 = 0; if0.readAddr2 = 0; if0.dumpStart = 0;
    if1.writeEnable = 0; if1.writeAddr = 0; if1.writeData = 0; if1.readReq = 0;
    if1.readAddr1 = 0; if1.readAddr2 = 0; if1.dumpStart = 0;

    // Reset state, before any clock edge
    #1 reset = 1'b1;
    #1;
    check("rst_readValid", 32'(if0.readValid), 32'd0);
    check("rst_readData1", if0.readData1, 32'd0);
    check("rst_busy",      32'(if0.busy), 32'd0);
    check("rst_dumpValid", 32'(if0.dumpValid), 32'd0);
    check("rst_dumpDone",  32'(if0.dumpDone), 32'd0);
    check("rst_dumpAddr",  32'(if0.dumpAddr), 32'd0);
    @(negedge clk) reset = 1'b0;

    // 1: read after reset
    if0.readReq = 1; if0.readAddr1 = 5;
    tick();
    check("t1_valid", 32'(if0.readValid), 32'd1);
    check("t1_data1", if0.readData1, 32'd0);

    // 2: write then read, single-cycle valid, hold
    if0.readReq = 0;
    if0.writeEnable = 1; if0.writeAddr = 3; if0.writeData = 32'd5;
    tick();
    check("t2_valid_low", 32'(if0.readValid), 32'd0);
    if0.writeEnable = 0;
    if0.readReq = 1; if0.readAddr1 = 3;
    tick();
    check("t2_data1", if0.readData1, 32'd5);
    check("t2_valid", 32'(if0.readValid), 32'd1);
    if0.readReq = 0;
    tick();
    check("t2_valid_pulse", 32'(if0.readValid), 32'd0);
    check("t2_hold", if0.readData1, 32'd5);

    // 3: forwarding on port 2, port 1 reads stored entry 3
    if0.writeEnable = 1; if0.writeAddr = 7; if0.writeData = 32'd25;
    if0.readReq = 1; if0.readAddr1 = 3; if0.readAddr2 = 7;
    tick();
    check("t3_fwd_data2", if0.readData2, 32'd25);
    check("t3_data1",     if0.readData1, 32'd5);
    if0.writeEnable = 0; if0.readAddr2 = 7;
    tick();
    check("t3_stored_data2", if0.readData2, 32'd25);
    check("t3_b2b_valid", 32'(if0.readValid), 32'd1);
    if0.readReq = 0;

    // 4: zero entry behaviour for both parameterisations
    if0.writeEnable = 1; if0.writeAddr = 0; if0.writeData = 32'd15;
    if1.writeEnable = 1; if1.writeAddr = 0; if1.writeData = 32'd15;
    if0.readReq = 1; if0.readAddr1 = 0;
    tick();
    check("t4_zr_nofwd", if0.readData1, 32'd0);
    if0.writeEnable = 0; if1.writeEnable = 0;
    if1.readReq = 1; if1.readAddr1 = 0;
    tick();
    check("t4_zr1_read0", if0.readData1, 32'd0);
    check("t4_zr0_read0", if1.readData1, 32'd15);
    if0.readReq = 0; if1.readReq = 0;

    // 5: full dump after clearing the bank with a mid-cycle reset
    #2 reset = 1'b1;
    #1 check("t5_rst_data1", if0.readData1, 32'd0);
    @(negedge clk) reset = 1'b0;
    for (int i = 0; i < 32; i++) exp_dump[i] = 32'd0;
    exp_dump[1] = 32'd5; exp_dump[2] = 32'd15; exp_dump[31] = 32'd25;
    if0.writeEnable = 1; if0.writeAddr = 1;  if0.writeData = 32'd5;  tick();
    if0.writeAddr = 2;  if0.writeData = 32'd15; tick();
    if0.writeAddr = 31; if0.writeData = 32'd25; tick();
    if0.writeEnable = 0;
    if0.dumpStart = 1;
    tick();
    if0.dumpStart = 0;
    check("t5_busy_start", 32'(if0.busy), 32'd1);
    check("t5_valid_start", 32'(if0.dumpValid), 32'd0);
    for (int i = 0; i < 32; i++) begin
      if0.dumpStart = (i == 5) ? 1'b1 : 1'b0;
      tick();
      check($sformatf("t5_valid_%0d", i), 32'(if0.dumpValid), 32'd1);
      check($sformatf("t5_addr_%0d", i),  32'(if0.dumpAddr), 32'(i));
      check($sformatf("t5_data_%0d", i),  if0.dumpData, exp_dump[i]);
      check($sformatf("t5_done_%0d", i),  32'(if0.dumpDone), (i == 31) ? 32'd1 : 32'd0);
    end
    if0.dumpStart = 0;
    check("t5_busy_end", 32'(if0.busy), 32'd0);
    tick();
    check("t5_valid_after", 32'(if0.dumpValid), 32'd0);
    check("t5_done_after",  32'(if0.dumpDone), 32'd0);
    check("t5_addr_hold",   32'(if0.dumpAddr), 32'd31);
    check("t5_data_hold",   if0.dumpData, 32'd25);

    // 6: reset during beat 10 aborts the dump, restart streams zeros
    if0.dumpStart = 1;
    tick();
    if0.dumpStart = 0;
    for (int i = 0; i <= 10; i++) tick();
    check("t6_beat10_addr", 32'(if0.dumpAddr), 32'd10);
    #2 reset = 1'b1;
    #1;
    check("t6_busy_rst",  32'(if0.busy), 32'd0);
    check("t6_valid_rst", 32'(if0.dumpValid), 32'd0);
    check("t6_done_rst",  32'(if0.dumpDone), 32'd0);
    @(negedge clk) reset = 1'b0;
    for (int i = 0; i < 25; i++) begin
      tick();
      check($sformatf("t6_nodone_%0d", i), 32'(if0.dumpDone | if0.dumpValid), 32'd0);
    end
    if0.dumpStart = 1;
    tick();
    if0.dumpStart = 0;
    for (int i = 0; i < 32; i++) begin
      tick();
      check($sformatf("t6_addr_%0d", i), 32'(if0.dumpAddr), 32'(i));
      check($sformatf("t6_data_%0d", i), if0.dumpData, 32'd0);
      check($sformatf("t6_done_%0d", i), 32'(if0.dumpDone), (i == 31) ? 32'd1 : 32'd0);
    end
    check("t6_busy_end", 32'(if0.busy), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
